// File: rtl/pe_exp_pkg.sv
// Shared types and constants for the iterative exp(x) unit.
package pe_exp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TAYLOR,
        SQUARE,
        DONE
    } exp_state_t;

    localparam int unsigned NUM_TERMS_DEF = 8;
    localparam int unsigned SQ_STEPS_DEF  = 4;
    localparam real         X_MIN_DEF     = -30.0;
    localparam int unsigned CNT_W         = 6;

    // Next Taylor term from the previous one: r^k/k! = (r^(k-1)/(k-1)!) * r / k
    function automatic real taylor_step(input real term, input real r,
                                        input logic [CNT_W-1:0] k);
        return term * r / real'(k);
    endfunction

endpackage

// File: rtl/pe_exp_taylor_if.sv
// Handshake bundle: argument in on the upstream side, exp(x) out downstream.
interface pe_exp_taylor_if;
    logic in_valid;
    logic in_ready;
    real  x_in;
    logic out_valid;
    logic out_ready;
    real  exp_out;

    // Driver side: feeds arguments and accepts results
    modport master (
        output in_valid, x_in, out_ready,
        input  in_ready, out_valid, exp_out
    );

    // Unit side
    modport slave (
        input  in_valid, x_in, out_ready,
        output in_ready, out_valid, exp_out
    );
endinterface

// File: rtl/pe_exp_taylor.sv
// Scaling-and-squaring exp(x): r = x/2^S, NUM_TERMS-term Taylor series in r,
// then S squarings. Fixed latency, valid/ready on both sides. Real-valued,
// intended for simulation and architecture exploration.
module pe_exp_taylor
    import pe_exp_pkg::*;
#(
    parameter int unsigned NUM_TERMS = NUM_TERMS_DEF,
    parameter int unsigned SQ_STEPS  = SQ_STEPS_DEF,
    parameter real         X_MIN     = X_MIN_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    pe_exp_taylor_if.slave        bus
);

    if (NUM_TERMS < 1 || NUM_TERMS > 32) begin : g_bad_num_terms
        $fatal(1, "pe_exp_taylor: NUM_TERMS=%0d outside 1..32", NUM_TERMS);
    end
    if (SQ_STEPS > 8) begin : g_bad_sq_steps
        $fatal(1, "pe_exp_taylor: SQ_STEPS=%0d outside 0..8", SQ_STEPS);
    end

    localparam int unsigned SQ_POW = 32'd1 << SQ_STEPS;
    localparam real         SQ_DIV = real'(SQ_POW);

    localparam logic [CNT_W-1:0] K_LAST = CNT_W'((NUM_TERMS > 1) ? NUM_TERMS - 1 : 0);
    localparam logic [CNT_W-1:0] S_LAST = CNT_W'((SQ_STEPS > 0) ? SQ_STEPS - 1 : 0);

    // Phases with no work to do are skipped outright, so latency stays
    // NUM_TERMS-1+SQ_STEPS edges after the accept for every parameter set.
    localparam exp_state_t AFTER_TAYLOR = (SQ_STEPS > 0) ? SQUARE : DONE;
    localparam exp_state_t AFTER_ACCEPT = (NUM_TERMS > 1) ? TAYLOR : AFTER_TAYLOR;

    exp_state_t       state_q, state_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic [CNT_W-1:0] s_q, s_d;
    real              r_q, r_d;
    real              term_q, term_d;
    real              sum_q, sum_d;
    real              exp_out_q, exp_out_d;
    logic             uflow_q, uflow_d;
    real              t_step;

    // Next-state, datapath update and result capture
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        s_d       = s_q;
        r_d       = r_q;
        term_d    = term_q;
        sum_d     = sum_q;
        uflow_d   = uflow_q;
        t_step    = 0.0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    r_d     = bus.x_in / SQ_DIV;
                    term_d  = 1.0;
                    sum_d   = 1.0;
                    k_d     = CNT_W'(1);
                    s_d     = '0;
                    uflow_d = (bus.x_in < X_MIN);
                    state_d = AFTER_ACCEPT;
                end
            end
            TAYLOR: begin
                t_step = taylor_step(term_q, r_q, k_q);
                term_d = t_step;
                sum_d  = sum_q + t_step;
                if (k_q == K_LAST) begin
                    state_d = AFTER_TAYLOR;
                end else begin
                    k_d = k_q + CNT_W'(1);
                end
            end
            SQUARE: begin
                sum_d = sum_q * sum_q;
                if (s_q == S_LAST) begin
                    state_d = DONE;
                end else begin
                    s_d = s_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Result is latched on entry to DONE and then held until the next job
        if (state_d == DONE && state_q != DONE) begin
            exp_out_d = uflow_d ? 0.0 : sum_d;
        end else begin
            exp_out_d = exp_out_q;
        end
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            k_q       <= '0;
            s_q       <= '0;
            r_q       <= 0.0;
            term_q    <= 0.0;
            sum_q     <= 0.0;
            exp_out_q <= 0.0;
            uflow_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            s_q       <= s_d;
            r_q       <= r_d;
            term_q    <= term_d;
            sum_q     <= sum_d;
            exp_out_q <= exp_out_d;
            uflow_q   <= uflow_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.exp_out   = exp_out_q;

endmodule

// File: tb/tb_pe_exp_taylor.sv
// Self-checking bench for pe_exp_taylor at default parameters.
module tb_pe_exp_taylor;

    localparam int unsigned NT    = 8;
    localparam int unsigned SQ    = 4;
    localparam real         XMIN  = -30.0;
    localparam int          LAT   = NT - 1 + SQ;
    localparam int          II    = NT + SQ + 1;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    real  last_out;

    pe_exp_taylor_if bus();

    pe_exp_taylor #(
        .NUM_TERMS (NT),
        .SQ_STEPS  (SQ),
        .X_MIN     (XMIN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic real rabs(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    // Reference: explicit power/factorial sum of the truncated series, then squaring
    function automatic real model_exp(input real x);
        real r, p, pw, fact;
        if (x < XMIN) return 0.0;
        r = x;
        for (int i = 0; i < SQ; i++) r = r / 2.0;
        p = 0.0;
        for (int k = 0; k < NT; k++) begin
            pw = 1.0;
            fact = 1.0;
            for (int j = 1; j <= k; j++) begin
                pw   = pw * r;
                fact = fact * real'(j);
            end
            p = p + pw / fact;
        end
        for (int i = 0; i < SQ; i++) p = p * p;
        return p;
    endfunction

    task automatic check(input string tag, input real got, input real want, input real tol);
        n_checks++;
        if (!(got == want || (tol > 0.0 && rabs(got - want) <= tol * rabs(want)))) begin
            n_errors++;
            $display("FAIL %s: got %0.12g expected %0.12g", tag, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One job; bp cycles of held-off out_ready once the result is up
    task automatic run_one(input real x, input int bp, input string tag);
        int   lat;
        int   w;
        real  held;
        w = 0;
        while (!bus.in_ready && w < 50) begin tick(); w++; end
        check({tag, " ready"}, real'(bus.in_ready), 1.0, 0.0);
        bus.out_ready = (bp == 0);
        bus.x_in      = x;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        bus.x_in      = 123.0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin tick(); lat++; end
        check({tag, " latency"}, real'(lat), real'(LAT), 0.0);
        check({tag, " value"}, bus.exp_out, model_exp(x), 1e-9);
        check({tag, " in_ready in DONE"}, real'(bus.in_ready), 0.0, 0.0);
        held = bus.exp_out;
        for (int i = 0; i < bp; i++) begin
            tick();
            check({tag, " bp out_valid"}, real'(bus.out_valid), 1.0, 0.0);
            check({tag, " bp exp_out"}, bus.exp_out, held, 0.0);
            check({tag, " bp in_ready"}, real'(bus.in_ready), 0.0, 0.0);
        end
        bus.out_ready = 1'b1;
        tick();
        check({tag, " back to idle"}, real'(bus.in_ready), 1.0, 0.0);
        check({tag, " valid drop"}, real'(bus.out_valid), 0.0, 0.0);
        check({tag, " held after"}, bus.exp_out, held, 0.0);
        last_out = held;
    endtask

    initial begin
        real xs[3];
        real outs[3];
        int  acc_cyc[3];
        int  nout, idx, cyc;
        logic acc;

        n_checks = 0;
        n_errors = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.x_in      = 0.0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("reset in_ready", real'(bus.in_ready), 1.0, 0.0);
        check("reset out_valid", real'(bus.out_valid), 0.0, 0.0);
        check("reset exp_out", bus.exp_out, 0.0, 0.0);

        run_one(0.0, 0, "x0");
        check("x0 exact", last_out, 1.0, 0.0);
        run_one(1.0, 0, "x1");
        check("x1 vs e", last_out, 2.718281828459045, 1e-9);
        run_one(-2.0, 0, "xm2");
        check("xm2 vs exp", last_out, 0.1353352832366127, 1e-9);
        run_one(-40.0, 0, "uflow");
        check("uflow zero", last_out, 0.0, 0.0);
        run_one(-29.0, 0, "xm29");
        check("xm29 near exp", last_out, $exp(-29.0), 0.5);
        run_one(-30.0, 0, "xmin edge");
        check("xmin not flushed", real'(last_out > 0.0), 1.0, 0.0);
        run_one(0.75, 5, "bp");

        // Back-to-back with in_valid held high
        xs[0] = 0.5; xs[1] = 1.5; xs[2] = -1.0;
        nout = 0; idx = 0; cyc = 0;
        bus.out_ready = 1'b1;
        bus.x_in      = xs[0];
        bus.in_valid  = 1'b1;
        while (nout < 3 && cyc < 100) begin
            if (bus.out_valid) begin
                outs[nout] = bus.exp_out;
                nout++;
            end
            acc = bus.in_ready && bus.in_valid;
            if (acc) acc_cyc[idx] = cyc;
            tick();
            cyc++;
            if (acc) begin
                idx++;
                if (idx < 3) bus.x_in = xs[idx];
                else bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        check("b2b outputs seen", real'(nout), 3.0, 0.0);
        check("b2b accepts", real'(idx), 3.0, 0.0);
        if (idx == 3) begin
            check("b2b ii 0-1", real'(acc_cyc[1] - acc_cyc[0]), real'(II), 0.0);
            check("b2b ii 1-2", real'(acc_cyc[2] - acc_cyc[1]), real'(II), 0.0);
        end
        if (nout == 3) begin
            check("b2b out0", outs[0], 1.6487212707, 1e-8);
            check("b2b out1", outs[1], 4.4816890703, 1e-8);
            check("b2b out2", outs[2], 0.3678794412, 1e-8);
        end
        tick();

        // Reset while squaring
        bus.out_ready = 1'b1;
        bus.x_in      = 2.0;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        for (int i = 0; i < NT; i++) tick();
        check("sq mid out_valid", real'(bus.out_valid), 0.0, 0.0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst sq out_valid", real'(bus.out_valid), 0.0, 0.0);
        check("rst sq exp_out", bus.exp_out, 0.0, 0.0);
        check("rst sq in_ready", real'(bus.in_ready), 1.0, 0.0);
        run_one(1.0, 0, "after rst");

        // Randomized arguments across the flush threshold
        for (int i = 0; i < 20; i++) begin
            real x;
            x = -40.0 + real'($urandom_range(0, 43000)) / 1000.0;
            run_one(x, int'($urandom_range(0, 2)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Absolute time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "timeout");
    end

endmodule
